tri_edge_sequencer: RTL and testbench

TRI_EDGE_SEQUENCER -- requirements
Module: tri_edge_sequencer

---
 rtl/raster_pkg.sv | 25 ++
 rtl/tri_edge_sequencer_if.sv | 58 +++++
 rtl/tri_edge_sequencer.sv | 136 +++++++++++++
 tb/tb_tri_edge_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared raster types: coordinate widths, vertex record, sequencer states.
// Imported by the triangle edge sequencer and its interfaces.
package raster_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } vertex_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  // Vertex index that closes an edge starting at vertex i (wraps 2 -> 0).
  function automatic logic [1:0] nxt_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/tri_edge_sequencer_if.sv
// Triangle command port and line-engine port of the edge sequencer.
// master drives the request, slave answers it.
interface tri_cmd_if;
  import raster_pkg::*;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [X_W-1:0] cmd_x1;
  logic [X_W-1:0] cmd_x2;
  logic [X_W-1:0] cmd_x3;
  logic [Y_W-1:0] cmd_y1;
  logic [Y_W-1:0] cmd_y2;
  logic [Y_W-1:0] cmd_y3;

  modport master (
    output cmd_valid,
    output cmd_x1, cmd_x2, cmd_x3,
    output cmd_y1, cmd_y2, cmd_y3,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_x1, cmd_x2, cmd_x3,
    input  cmd_y1, cmd_y2, cmd_y3,
    output cmd_ready
  );

endinterface

interface tri_ln_if;
  import raster_pkg::*;

  logic           ln_start;
  logic [X_W-1:0] ln_x0;
  logic [X_W-1:0] ln_x1;
  logic [Y_W-1:0] ln_y0;
  logic [Y_W-1:0] ln_y1;
  logic           ln_busy;
  logic           ln_done;

  modport master (
    output ln_start,
    output ln_x0, ln_x1,
    output ln_y0, ln_y1,
    input  ln_busy,
    input  ln_done
  );

  modport slave (
    input  ln_start,
    input  ln_x0, ln_x1,
    input  ln_y0, ln_y1,
    output ln_busy,
    output ln_done
  );

endinterface

// File: rtl/tri_edge_sequencer.sv
// Walks the three edges of a triangle and hands each one to a line engine,
// skipping degenerate edges and aborting to ERR on a stalled engine.
module tri_edge_sequencer
  import raster_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  tri_cmd_if.slave         cmd,
  tri_ln_if.master         ln,
  output logic [1:0]       edge_idx,
  output logic             tri_done,
  output logic             busy,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] tri_count
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  vertex_t [2:0]    v_q, v_d;
  vertex_t          p0_q, p0_d;
  vertex_t          p1_q, p1_d;
  logic [1:0]       edge_q, edge_d;
  logic [15:0]      tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       degen;
  logic [1:0] ni;

  assign degen = (p0_q == p1_q);
  assign ni    = edge_q + 2'd1;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    edge_d  = edge_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (cmd.cmd_valid) begin
          v_d[0]  = {cmd.cmd_x1, cmd.cmd_y1};
          v_d[1]  = {cmd.cmd_x2, cmd.cmd_y2};
          v_d[2]  = {cmd.cmd_x3, cmd.cmd_y3};
          p0_d    = {cmd.cmd_x1, cmd.cmd_y1};
          p1_d    = {cmd.cmd_x2, cmd.cmd_y2};
          edge_d  = 2'd0;
          state_d = S_ISSUE;
        end
      end
      (state_q == S_ISSUE): begin
        if (degen) begin
          state_d = S_NEXT;
        end else if (!ln.ln_busy) begin
          tmo_d   = 16'd0;
          state_d = S_WAIT;
        end
      end
      (state_q == S_WAIT): begin
        tmo_d = tmo_q + 16'd1;
        // A completion in the timeout cycle still counts as success.
        if (ln.ln_done) begin
          state_d = S_NEXT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      (state_q == S_NEXT): begin
        if (edge_q == 2'd2) begin
          state_d = S_DONE;
        end else begin
          edge_d  = ni;
          p0_d    = v_q[ni];
          p1_d    = v_q[nxt_idx(ni)];
          state_d = S_ISSUE;
        end
      end
      (state_q == S_DONE): begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      (state_q == S_ERR): begin
        if (err_clr) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      v_q     <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      edge_q  <= 2'd0;
      tmo_q   <= 16'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      edge_q  <= edge_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign ln.ln_start   = (state_q == S_ISSUE)
                       && !degen && !ln.ln_busy;
  assign ln.ln_x0      = p0_q.x;
  assign ln.ln_y0      = p0_q.y;
  assign ln.ln_x1      = p1_q.x;
  assign ln.ln_y1      = p1_q.y;
  assign edge_idx      = edge_q;
  assign tri_done      = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign err           = err_q;
  assign tri_count     = cnt_q;

endmodule

// File: tb/tb_tri_edge_sequencer.sv
// Directed bench: instance A (TIMEOUT 8, 16-bit count) and
// instance B (TIMEOUT 4, 2-bit count) driven from one vector table.
module tb_tri_edge_sequencer;
  import raster_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       va, vb, sel;
  logic       ln_busy, ln_done, err_clr;
  logic [9:0] x1, x2, x3;
  logic [8:0] y1, y2, y3;

  tri_cmd_if ca ();
  tri_cmd_if cb ();
  tri_ln_if  la ();
  tri_ln_if  lb ();

  assign ca.cmd_valid = va;
  assign cb.cmd_valid = vb;
  assign ca.cmd_x1 = x1;
  assign ca.cmd_x2 = x2;
  assign ca.cmd_x3 = x3;
  assign ca.cmd_y1 = y1;
  assign ca.cmd_y2 = y2;
  assign ca.cmd_y3 = y3;
  assign cb.cmd_x1 = x1;
  assign cb.cmd_x2 = x2;
  assign cb.cmd_x3 = x3;
  assign cb.cmd_y1 = y1;
  assign cb.cmd_y2 = y2;
  assign cb.cmd_y3 = y3;
  assign la.ln_busy = ln_busy;
  assign la.ln_done = ln_done;
  assign lb.ln_busy = ln_busy;
  assign lb.ln_done = ln_done;

  logic [1:0]  ea, eb;
  logic        tda, tdb, ba, bb, era, erb;
  logic [15:0] cnta;
  logic [1:0]  cntb;

  tri_edge_sequencer #(.TIMEOUT(8), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .cmd(ca), .ln(la),
    .edge_idx(ea), .tri_done(tda), .busy(ba),
    .err(era), .err_clr(err_clr), .tri_count(cnta)
  );

  tri_edge_sequencer #(.TIMEOUT(4), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .cmd(cb), .ln(lb),
    .edge_idx(eb), .tri_done(tdb), .busy(bb),
    .err(erb), .err_clr(err_clr), .tri_count(cntb)
  );

  logic        o_ready, o_start, o_td, o_busy, o_err;
  logic [1:0]  o_edge;
  logic [15:0] o_cnt;
  logic [37:0] o_ends;

  assign o_ready = sel ? cb.cmd_ready : ca.cmd_ready;
  assign o_start = sel ? lb.ln_start : la.ln_start;
  assign o_td    = sel ? tdb : tda;
  assign o_busy  = sel ? bb : ba;
  assign o_err   = sel ? erb : era;
  assign o_edge  = sel ? eb : ea;
  assign o_cnt   = sel ? {14'd0, cntb} : cnta;
  assign o_ends  = sel
    ? {lb.ln_x0, lb.ln_y0, lb.ln_x1, lb.ln_y1}
    : {la.ln_x0, la.ln_y0, la.ln_x1, la.ln_y1};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          sel;
    logic [9:0]  x1, x2, x3;
    logic [8:0]  y1, y2, y3;
    int          dly;
    int          busy_len;
    int          n_st;
    int          first;
    int          lat;
    logic [37:0] e0, e1, e2;
    logic [15:0] cnt;
  } vec_t;

  function automatic logic [37:0] ep(int ax, int ay, int bx, int by);
    return {10'(ax), 9'(ay), 10'(bx), 9'(by)};
  endfunction

  function automatic vec_t mk(
    bit s, int ax, int ay, int bx, int by, int cx, int cy,
    int dly, int bl, int n, int fst, int lat,
    logic [37:0] e0, logic [37:0] e1, logic [37:0] e2, int cnt);
    vec_t v;
    v.sel = s;
    v.x1 = 10'(ax); v.y1 = 9'(ay);
    v.x2 = 10'(bx); v.y2 = 9'(by);
    v.x3 = 10'(cx); v.y3 = 9'(cy);
    v.dly = dly; v.busy_len = bl;
    v.n_st = n; v.first = fst; v.lat = lat;
    v.e0 = e0; v.e1 = e1; v.e2 = e2;
    v.cnt = 16'(cnt);
    return v;
  endfunction

  function automatic logic [37:0] ex(vec_t v, int k);
    return (k == 0) ? v.e0 : (k == 1) ? v.e1 : v.e2;
  endfunction

  task automatic load(vec_t v);
    x1 = v.x1; x2 = v.x2; x3 = v.x3;
    y1 = v.y1; y2 = v.y2; y3 = v.y3;
  endtask

  // Present the command and return at the falling edge after the handshake.
  task automatic hs(bit s);
    sel = s;
    va  = !s;
    vb  = s;
    #1 chk("cmd_ready_idle", o_ready, 1);
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic run_tri(vec_t v, int id);
    int st, fst, lat, dt, bt;
    bit stable;
    st = 0; fst = -1; lat = -1; dt = 0; bt = 0; stable = 1;
    ln_busy = 0; ln_done = 0;
    load(v);
    hs(v.sel);
    for (int c = 1; c <= 200; c++) begin
      ln_done = 0;
      if (dt > 0) begin
        dt--;
        if (dt == 0) begin
          ln_done = 1;
          if (st == 1 && v.busy_len > 0) bt = v.busy_len;
        end
      end
      ln_busy = (bt > 0);
      if (bt > 0) bt--;
      #1;
      if (o_start) begin
        if (st == 0) fst = c;
        if (st < 3)
          chk($sformatf("v%0d_ends%0d", id, st), o_ends, ex(v, st));
        st++;
        dt = v.dly;
      end
      if (ln_busy && st == 1 && o_edge == 2'd1 && o_ends !== v.e1)
        stable = 0;
      if (o_td) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    ln_done = 0;
    ln_busy = 0;
    chk($sformatf("v%0d_starts", id), st, v.n_st);
    chk($sformatf("v%0d_first", id), fst, v.first);
    chk($sformatf("v%0d_done_cyc", id), lat, v.lat);
    chk($sformatf("v%0d_stable", id), stable, 1);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_td_pulse", id), o_td, 0);
    chk($sformatf("v%0d_ready", id), o_ready, 1);
    chk($sformatf("v%0d_count", id), o_cnt, v.cnt);
    chk($sformatf("v%0d_err", id), o_err, 0);
  endtask

  vec_t tv[11];
  bit   saw_start, saw_td;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tv[0] = mk(0, 200,100, 400,300, 100,300, 3, 0, 3, 1, 16,
               ep(200,100,400,300), ep(400,300,100,300),
               ep(100,300,200,100), 1);
    tv[1] = mk(0, 50,50, 50,50, 50,50, 3, 0, 0, -1, 7,
               0, 0, 0, 2);
    tv[2] = mk(0, 10,20, 10,20, 30,40, 3, 0, 2, 3, 13,
               ep(10,20,30,40), ep(30,40,10,20), 0, 3);
    tv[3] = mk(0, 5,1, 5,2, 5,1, 3, 0, 2, 1, 13,
               ep(5,1,5,2), ep(5,2,5,1), 0, 4);
    tv[4] = mk(0, 0,0, 1023,511, 0,511, 3, 20, 3, 1, 34,
               ep(0,0,1023,511), ep(1023,511,0,511),
               ep(0,511,0,0), 5);
    tv[5] = mk(1, 7,7, 7,7, 7,7, 3, 0, 0, -1, 7, 0, 0, 0, 1);
    tv[6] = mk(1, 7,7, 7,7, 7,7, 3, 0, 0, -1, 7, 0, 0, 0, 2);
    tv[7] = mk(1, 7,7, 7,7, 7,7, 3, 0, 0, -1, 7, 0, 0, 0, 3);
    tv[8] = mk(1, 7,7, 7,7, 7,7, 3, 0, 0, -1, 7, 0, 0, 0, 0);
    tv[9] = mk(1, 7,7, 7,7, 7,7, 3, 0, 0, -1, 7, 0, 0, 0, 1);
    tv[10] = mk(1, 200,100, 400,300, 100,300, 4, 0, 3, 1, 19,
                ep(200,100,400,300), ep(400,300,100,300),
                ep(100,300,200,100), 2);

    va = 0; vb = 0; sel = 0;
    ln_busy = 0; ln_done = 0; err_clr = 0;
    x1 = 0; x2 = 0; x3 = 0; y1 = 0; y2 = 0; y3 = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk($sformatf("rst%0d_ready", s), o_ready, 1);
      chk($sformatf("rst%0d_start", s), o_start, 0);
      chk($sformatf("rst%0d_td", s), o_td, 0);
      chk($sformatf("rst%0d_busy", s), o_busy, 0);
      chk($sformatf("rst%0d_err", s), o_err, 0);
      chk($sformatf("rst%0d_edge", s), o_edge, 0);
      chk($sformatf("rst%0d_cnt", s), o_cnt, 0);
      chk($sformatf("rst%0d_ends", s), o_ends, 0);
    end
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_tri(tv[i], i);

    // Stalled line engine on A: eight WAIT cycles then ERR.
    load(tv[0]);
    hs(0);
    for (int c = 1; c <= 12; c++) begin
      err_clr = (c == 5) || (c == 12);
      #1;
      if (c == 1) chk("tmo_start", o_start, 1);
      if (c == 9) begin
        chk("tmo_wait_err", o_err, 0);
        chk("tmo_wait_busy", o_busy, 1);
      end
      if (c == 10) begin
        chk("tmo_err", o_err, 1);
        chk("tmo_ready", o_ready, 0);
        chk("tmo_nostart", o_start, 0);
        chk("tmo_busy", o_busy, 1);
      end
      if (c == 11) chk("tmo_sticky", o_err, 1);
      @(negedge clk);
    end
    err_clr = 0;
    #1;
    chk("clr_err", o_err, 0);
    chk("clr_ready", o_ready, 1);
    chk("clr_busy", o_busy, 0);
    chk("clr_cnt", o_cnt, 5);
    @(negedge clk);

    // Reset while edge 1 is in flight on A.
    load(tv[0]);
    hs(0);
    for (int c = 1; c <= 7; c++) begin
      ln_done = (c == 4);
      #1;
      if (c == 6) begin
        chk("mid_start1", o_start, 1);
        chk("mid_ends1", o_ends, tv[0].e1);
      end
      @(negedge clk);
    end
    ln_done = 0;
    #2 rst = 1;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_edge", o_edge, 0);
    chk("arst_ends", o_ends, 0);
    chk("arst_cnt", o_cnt, 0);
    chk("arst_start", o_start, 0);
    chk("arst_err", o_err, 0);
    @(negedge clk);
    rst = 0;
    #1 chk("arst_ready", o_ready, 1);
    saw_start = 0;
    saw_td = 0;
    for (int i = 1; i <= 20; i++) begin
      ln_done = (i == 1);
      #1;
      if (o_start) saw_start = 1;
      if (o_td) saw_td = 1;
      @(negedge clk);
    end
    ln_done = 0;
    chk("arst_no_start", saw_start, 0);
    chk("arst_no_td", saw_td, 0);
    chk("arst_cnt_after", o_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
